// File: rtl/hazard_ctrl_pkg.sv
// Shared constants, control-bundle type and output-pattern helpers for the
// pipeline hazard/sequencing controller.
package hazard_ctrl_pkg;

   localparam logic [1:0] RUN   = 2'd0;
   localparam logic [1:0] DRAIN = 2'd1;
   localparam logic [1:0] HALT  = 2'd2;

   localparam logic [5:0] HALT_OPCODE  = 6'b111111;
   localparam int         DRAIN_CYCLES = 3;
   localparam int         DRAIN_W      = $clog2(DRAIN_CYCLES + 1);

   typedef struct packed {
      logic pc_write;
      logic ifid_write;
      logic ifid_flush;
      logic idex_flush;
      logic exmem_flush;
      logic pipe_en;
   } ctrl_t;

   function automatic logic is_halt_opcode(input logic [5:0] opcode);
      return opcode == HALT_OPCODE;
   endfunction

   function automatic ctrl_t ctrl_idle();
      ctrl_t c;
      c = '0;
      return c;
   endfunction

   function automatic ctrl_t ctrl_run();
      ctrl_t c;
      c            = '0;
      c.pc_write   = 1'b1;
      c.ifid_write = 1'b1;
      c.pipe_en    = 1'b1;
      return c;
   endfunction

   // IF/ID keeps its enable so the NOP actually gets loaded on a redirect.
   function automatic ctrl_t ctrl_redirect();
      ctrl_t c;
      c             = '0;
      c.pc_write    = 1'b1;
      c.ifid_write  = 1'b1;
      c.ifid_flush  = 1'b1;
      c.idex_flush  = 1'b1;
      c.exmem_flush = 1'b1;
      c.pipe_en     = 1'b1;
      return c;
   endfunction

   function automatic ctrl_t ctrl_bubble();
      ctrl_t c;
      c            = '0;
      c.idex_flush = 1'b1;
      c.pipe_en    = 1'b1;
      return c;
   endfunction

   function automatic ctrl_t ctrl_reset();
      ctrl_t c;
      c             = '0;
      c.ifid_flush  = 1'b1;
      c.idex_flush  = 1'b1;
      c.exmem_flush = 1'b1;
      return c;
   endfunction

endpackage

// File: rtl/hazard_control_unit_load_use_detect.sv
// Combinational load-use compare between the load in ID/EX and the operands
// of the instruction in IF/ID; register $0 never creates a dependency.
module load_use_detect #(
   parameter int W = 5
) (
   input  logic         ex_mem_read,
   input  logic [W-1:0] ex_rt,
   input  logic [W-1:0] id_rs,
   input  logic [W-1:0] id_rt,
   output logic         hazard
);

   logic rs_match;
   logic rt_match;
   logic dest_live;

   always_comb begin
      dest_live = ex_rt != '0;
      rs_match  = ex_rt == id_rs;
      rt_match  = ex_rt == id_rt;
      hazard    = ex_mem_read && dest_live && (rs_match || rt_match);
   end

endmodule

// File: rtl/hazard_control_unit.sv
// Pipeline sequencing controller: load-use stalls, redirect squash,
// halt-and-drain and debug single-step for the 5-stage MIPS core.
module hazard_control_unit
   import hazard_ctrl_pkg::*;
#(
   parameter int W     = 5,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [W-1:0]     id_rs,
   input  logic [W-1:0]     id_rt,
   input  logic             id_halt,
   input  logic             ex_mem_read,
   input  logic [W-1:0]     ex_rt,
   input  logic             mem_pc_src,
   input  logic             dbg_mode,
   input  logic             dbg_step,
   output logic             pc_write,
   output logic             ifid_write,
   output logic             ifid_flush,
   output logic             idex_flush,
   output logic             exmem_flush,
   output logic             pipe_en,
   output logic             halted,
   output logic [CNT_W-1:0] stall_cycles
);

   logic [1:0]         state_q, state_d;
   logic [DRAIN_W-1:0] drain_cnt_q, drain_cnt_d;
   logic [CNT_W-1:0]   stall_cycles_q, stall_cycles_d;
   logic               hazard;
   logic               adv;
   ctrl_t              ctrl;

   load_use_detect #(
      .W(W)
   ) u_load_use_detect (
      .ex_mem_read(ex_mem_read),
      .ex_rt      (ex_rt),
      .id_rs      (id_rs),
      .id_rt      (id_rt),
      .hazard     (hazard)
   );

   // Nothing moves unless the pipeline is allowed to advance this cycle.
   always_comb begin
      state_d        = state_q;
      drain_cnt_d    = drain_cnt_q;
      stall_cycles_d = stall_cycles_q;
      ctrl           = ctrl_idle();
      adv            = (state_q != HALT) && (!dbg_mode || dbg_step);

      if (adv) begin
         case (state_q)
            RUN: begin
               if (mem_pc_src) begin
                  ctrl = ctrl_redirect();
               end else if (hazard) begin
                  ctrl = ctrl_bubble();
                  if (stall_cycles_q != {CNT_W{1'b1}}) begin
                     stall_cycles_d = stall_cycles_q + CNT_W'(1);
                  end
               end else if (id_halt) begin
                  ctrl        = ctrl_bubble();
                  state_d     = DRAIN;
                  drain_cnt_d = DRAIN_W'(DRAIN_CYCLES - 1);
               end else begin
                  ctrl = ctrl_run();
               end
            end
            DRAIN: begin
               if (mem_pc_src) begin
                  ctrl        = ctrl_redirect();
                  state_d     = RUN;
                  drain_cnt_d = '0;
               end else begin
                  ctrl = ctrl_bubble();
                  if (drain_cnt_q == '0) begin
                     state_d = HALT;
                  end else begin
                     drain_cnt_d = drain_cnt_q - DRAIN_W'(1);
                  end
               end
            end
            default: begin
               ctrl        = ctrl_idle();
               state_d     = RUN;
               drain_cnt_d = '0;
            end
         endcase
      end

      if (reset) begin
         ctrl = ctrl_reset();
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= RUN;
         drain_cnt_q    <= '0;
         stall_cycles_q <= '0;
      end else begin
         state_q        <= state_d;
         drain_cnt_q    <= drain_cnt_d;
         stall_cycles_q <= stall_cycles_d;
      end
   end

   assign pc_write     = ctrl.pc_write;
   assign ifid_write   = ctrl.ifid_write;
   assign ifid_flush   = ctrl.ifid_flush;
   assign idex_flush   = ctrl.idex_flush;
   assign exmem_flush  = ctrl.exmem_flush;
   assign pipe_en      = ctrl.pipe_en;
   assign halted       = !reset && (state_q == HALT);
   assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_hazard_control_unit.sv
// Self-checking bench for hazard_control_unit: directed vector table,
// multi-cycle corner sequences and randomized traffic against a behavioural model.
module tb_hazard_control_unit;

   localparam logic [5:0] C_RST   = 6'b001110;
   localparam logic [5:0] C_NORM  = 6'b110001;
   localparam logic [5:0] C_STALL = 6'b000101;
   localparam logic [5:0] C_REDIR = 6'b111111;
   localparam logic [5:0] C_IDLE  = 6'b000000;

   typedef struct packed {
      logic       rst;
      logic       halt;
      logic       mread;
      logic       psrc;
      logic       dmode;
      logic       dstep;
      logic [4:0] rs;
      logic [4:0] rt;
      logic [4:0] ert;
   } stim_t;

   typedef struct {
      stim_t       in;
      logic [5:0]  exp_ctl;
      logic        exp_halted;
      logic [15:0] exp_stall;
   } vec_t;

   logic        clk;
   logic        reset;
   logic [4:0]  id_rs, id_rt, ex_rt;
   logic        id_halt, ex_mem_read, mem_pc_src, dbg_mode, dbg_step;
   logic        pc_write, ifid_write, ifid_flush, idex_flush, exmem_flush, pipe_en, halted;
   logic [15:0] stall_cycles;
   logic        s_pc_write, s_ifid_write, s_ifid_flush, s_idex_flush, s_exmem_flush, s_pipe_en, s_halted;
   logic [2:0]  s_stall_cycles;
   logic [5:0]  act_ctl;

   int n_checks = 0;
   int n_errors = 0;

   bit m_halted;
   int m_drain_left;
   int m_stall;

   hazard_control_unit #(.W(5), .CNT_W(16)) dut (
      .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_halt(id_halt),
      .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .mem_pc_src(mem_pc_src),
      .dbg_mode(dbg_mode), .dbg_step(dbg_step), .pc_write(pc_write),
      .ifid_write(ifid_write), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
      .exmem_flush(exmem_flush), .pipe_en(pipe_en), .halted(halted),
      .stall_cycles(stall_cycles)
   );

   // Narrow counter copy so saturation is reachable in a few cycles.
   hazard_control_unit #(.W(5), .CNT_W(3)) dut_sat (
      .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_halt(id_halt),
      .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .mem_pc_src(mem_pc_src),
      .dbg_mode(dbg_mode), .dbg_step(dbg_step), .pc_write(s_pc_write),
      .ifid_write(s_ifid_write), .ifid_flush(s_ifid_flush), .idex_flush(s_idex_flush),
      .exmem_flush(s_exmem_flush), .pipe_en(s_pipe_en), .halted(s_halted),
      .stall_cycles(s_stall_cycles)
   );

   assign act_ctl = {pc_write, ifid_write, ifid_flush, idex_flush, exmem_flush, pipe_en};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation time limit expired");
      $fatal(1, "[TB] watchdog");
   end

   function automatic stim_t mk(input logic [5:0] flags, input logic [4:0] rs,
                                input logic [4:0] rt, input logic [4:0] ert);
      stim_t s;
      {s.rst, s.halt, s.mread, s.psrc, s.dmode, s.dstep} = flags;
      s.rs  = rs;
      s.rt  = rt;
      s.ert = ert;
      return s;
   endfunction

   task automatic apply_stimulus(input stim_t s);
      reset       = s.rst;
      id_halt     = s.halt;
      ex_mem_read = s.mread;
      mem_pc_src  = s.psrc;
      dbg_mode    = s.dmode;
      dbg_step    = s.dstep;
      id_rs       = s.rs;
      id_rt       = s.rt;
      ex_rt       = s.ert;
   endtask

   task automatic check_val(input string name, input string what,
                            input logic [15:0] act, input logic [15:0] req);
      n_checks++;
      if (act !== req) begin
         n_errors++;
         $display("[TB] FAIL %s %s: actual=%0h required=%0h", name, what, act, req);
      end
   endtask

   task automatic check_output(input string name, input logic [5:0] e_ctl,
                               input logic e_h, input logic [15:0] e_stall);
      check_val(name, "ctl{pcw,ifw,iff,idf,exf,pen}", 16'(act_ctl), 16'(e_ctl));
      check_val(name, "halted", 16'(halted), 16'(e_h));
      check_val(name, "stall_cycles", stall_cycles, e_stall);
   endtask

   task automatic run_cycle(input string name, input stim_t s, input logic [5:0] e_ctl,
                            input logic e_h, input logic [15:0] e_stall);
      @(posedge clk);
      #1;
      apply_stimulus(s);
      @(negedge clk);
      check_output(name, e_ctl, e_h, e_stall);
   endtask

   task automatic reset_dut();
      for (int i = 0; i < 2; i++) begin
         @(posedge clk);
         #1;
         apply_stimulus(mk(6'b100000, 5'd0, 5'd0, 5'd0));
      end
   endtask

   // Reference behaviour: one call per clock, returns this cycle's outputs
   // and advances the abstract machine to the next cycle.
   task automatic model_step(input stim_t s, output logic [5:0] e_ctl,
                             output logic e_h, output logic [15:0] e_stall);
      bit adv;
      bit hz;
      e_stall = 16'(m_stall);
      e_h     = m_halted && !s.rst;
      hz      = s.mread && (s.ert != 5'd0) && ((s.ert == s.rs) || (s.ert == s.rt));
      adv     = !m_halted && (!s.dmode || s.dstep);
      if (s.rst) begin
         e_ctl        = C_RST;
         m_halted     = 1'b0;
         m_drain_left = 0;
         m_stall      = 0;
      end else if (!adv) begin
         e_ctl = C_IDLE;
      end else if (s.psrc) begin
         e_ctl        = C_REDIR;
         m_drain_left = 0;
      end else if (m_drain_left > 0) begin
         e_ctl = C_STALL;
         m_drain_left--;
         if (m_drain_left == 0) m_halted = 1'b1;
      end else if (hz) begin
         e_ctl = C_STALL;
         if (m_stall < 65535) m_stall++;
      end else if (s.halt) begin
         e_ctl        = C_STALL;
         m_drain_left = 3;
      end else begin
         e_ctl = C_NORM;
      end
   endtask

   initial begin
      vec_t        tbl [15];
      stim_t       s;
      logic [5:0]  ec;
      logic        eh;
      logic [15:0] es;

      apply_stimulus(mk(6'b100000, 5'd0, 5'd0, 5'd0));

      // flags = {rst, halt, mread, psrc, dmode, dstep}
      tbl[0]  = '{mk(6'b100000, 5'd0, 5'd0, 5'd0), C_RST,   1'b0, 16'd0};
      tbl[1]  = '{mk(6'b000000, 5'd1, 5'd2, 5'd0), C_NORM,  1'b0, 16'd0};
      tbl[2]  = '{mk(6'b001000, 5'd2, 5'd4, 5'd2), C_STALL, 1'b0, 16'd0};
      tbl[3]  = '{mk(6'b000000, 5'd2, 5'd4, 5'd2), C_NORM,  1'b0, 16'd1};
      tbl[4]  = '{mk(6'b001000, 5'd0, 5'd0, 5'd0), C_NORM,  1'b0, 16'd1};
      tbl[5]  = '{mk(6'b001000, 5'd3, 5'd7, 5'd7), C_STALL, 1'b0, 16'd1};
      tbl[6]  = '{mk(6'b001000, 5'd3, 5'd4, 5'd7), C_NORM,  1'b0, 16'd2};
      tbl[7]  = '{mk(6'b011100, 5'd5, 5'd6, 5'd5), C_REDIR, 1'b0, 16'd2};
      tbl[8]  = '{mk(6'b000000, 5'd5, 5'd6, 5'd5), C_NORM,  1'b0, 16'd2};
      tbl[9]  = '{mk(6'b001010, 5'd5, 5'd6, 5'd5), C_IDLE,  1'b0, 16'd2};
      tbl[10] = '{mk(6'b001011, 5'd5, 5'd6, 5'd5), C_STALL, 1'b0, 16'd2};
      tbl[11] = '{mk(6'b001010, 5'd5, 5'd6, 5'd5), C_IDLE,  1'b0, 16'd3};
      tbl[12] = '{mk(6'b000001, 5'd5, 5'd6, 5'd5), C_NORM,  1'b0, 16'd3};
      tbl[13] = '{mk(6'b011000, 5'd1, 5'd2, 5'd1), C_STALL, 1'b0, 16'd3};
      tbl[14] = '{mk(6'b000000, 5'd1, 5'd2, 5'd0), C_NORM,  1'b0, 16'd4};

      for (int i = 0; i < 15; i++) begin
         run_cycle($sformatf("vec%0d", i), tbl[i].in, tbl[i].exp_ctl,
                   tbl[i].exp_halted, tbl[i].exp_stall);
      end

      // Halt-and-drain, then nothing but reset may leave HALT.
      reset_dut();
      run_cycle("halt_req", mk(6'b010000, 5'd1, 5'd2, 5'd0), C_STALL, 1'b0, 16'd0);
      for (int i = 0; i < 3; i++) begin
         run_cycle($sformatf("drain%0d", i), mk(6'b000000, 5'd1, 5'd2, 5'd0), C_STALL, 1'b0, 16'd0);
      end
      run_cycle("halted", mk(6'b000000, 5'd1, 5'd2, 5'd0), C_IDLE, 1'b1, 16'd0);
      run_cycle("halted_step", mk(6'b001111, 5'd1, 5'd2, 5'd1), C_IDLE, 1'b1, 16'd0);
      run_cycle("halted_hold", mk(6'b000000, 5'd1, 5'd2, 5'd0), C_IDLE, 1'b1, 16'd0);
      run_cycle("halted_reset", mk(6'b100000, 5'd1, 5'd2, 5'd0), C_RST, 1'b0, 16'd0);
      run_cycle("after_halt_reset", mk(6'b000000, 5'd1, 5'd2, 5'd0), C_NORM, 1'b0, 16'd0);

      // Wrong-path halt squashed by a redirect on the second drain cycle.
      reset_dut();
      run_cycle("wp_halt", mk(6'b010000, 5'd1, 5'd2, 5'd0), C_STALL, 1'b0, 16'd0);
      run_cycle("wp_drain1", mk(6'b000000, 5'd1, 5'd2, 5'd0), C_STALL, 1'b0, 16'd0);
      run_cycle("wp_redirect", mk(6'b000100, 5'd1, 5'd2, 5'd0), C_REDIR, 1'b0, 16'd0);
      for (int i = 0; i < 5; i++) begin
         run_cycle($sformatf("wp_run%0d", i), mk(6'b000000, 5'd1, 5'd2, 5'd0), C_NORM, 1'b0, 16'd0);
      end

      // Reset in the middle of a drain returns straight to RUN.
      reset_dut();
      run_cycle("rd_halt", mk(6'b010000, 5'd1, 5'd2, 5'd0), C_STALL, 1'b0, 16'd0);
      run_cycle("rd_drain", mk(6'b000000, 5'd1, 5'd2, 5'd0), C_STALL, 1'b0, 16'd0);
      run_cycle("rd_reset", mk(6'b100000, 5'd1, 5'd2, 5'd0), C_RST, 1'b0, 16'd0);
      for (int i = 0; i < 4; i++) begin
         run_cycle($sformatf("rd_run%0d", i), mk(6'b000000, 5'd1, 5'd2, 5'd0), C_NORM, 1'b0, 16'd0);
      end

      // Step mode: idle without pulses, one pulse gives exactly one stall.
      reset_dut();
      run_cycle("st_pre", mk(6'b001000, 5'd3, 5'd4, 5'd3), C_STALL, 1'b0, 16'd0);
      for (int i = 0; i < 10; i++) begin
         run_cycle($sformatf("st_wait%0d", i), mk(6'b001010, 5'd3, 5'd4, 5'd3), C_IDLE, 1'b0, 16'd1);
      end
      run_cycle("st_pulse", mk(6'b001011, 5'd3, 5'd4, 5'd3), C_STALL, 1'b0, 16'd1);
      run_cycle("st_after", mk(6'b001010, 5'd3, 5'd4, 5'd3), C_IDLE, 1'b0, 16'd2);

      // Counter saturation on the 3-bit instance.
      reset_dut();
      for (int i = 0; i < 10; i++) begin
         run_cycle($sformatf("sat%0d", i), mk(6'b001000, 5'd6, 5'd1, 5'd6), C_STALL, 1'b0, 16'(i));
         check_val($sformatf("sat%0d", i), "narrow stall_cycles", 16'(s_stall_cycles),
                   16'((i > 7) ? 7 : i));
      end

      reset_dut();
      m_halted     = 1'b0;
      m_drain_left = 0;
      m_stall      = 0;
      for (int i = 0; i < 3000; i++) begin
         s.rst   = ($urandom_range(63, 0) == 0);
         s.halt  = ($urandom_range(15, 0) == 0);
         s.mread = ($urandom_range(1, 0) == 1);
         s.psrc  = ($urandom_range(7, 0) == 0);
         s.dmode = ($urandom_range(3, 0) == 0);
         s.dstep = ($urandom_range(1, 0) == 1);
         s.rs    = 5'($urandom_range(3, 0));
         s.rt    = 5'($urandom_range(3, 0));
         s.ert   = 5'($urandom_range(3, 0));
         model_step(s, ec, eh, es);
         run_cycle($sformatf("rand%0d", i), s, ec, eh, es);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
